// File: rtl/game_pkg.sv
// Shared constants for the brick-breaker game-phase sequencer: phase encodings,
// life/level limits and the saturating level increment.
package game_pkg;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_LOAD  = 3'd1;
    localparam logic [2:0] PH_SERVE = 3'd2;
    localparam logic [2:0] PH_PLAY  = 3'd3;
    localparam logic [2:0] PH_MISS  = 3'd4;
    localparam logic [2:0] PH_CLEAR = 3'd5;
    localparam logic [2:0] PH_OVER  = 3'd6;

    localparam logic [2:0] LIFE_FULL = 3'b111;
    localparam logic [2:0] LIFE_LAST = 3'b100;
    localparam logic [3:0] LEVEL_MAX = 4'd15;

    function automatic logic [3:0] level_inc(input logic [3:0] lvl);
        return (lvl == LEVEL_MAX) ? lvl : lvl + 4'd1;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Modulo-N counter with enable and synchronous clear; tc_o strobes combinationally
// on an enabled cycle at count N-1 (the count then wraps to 0).
module tick_div #(
    parameter int unsigned N = 2
) (
    input  logic buttonclk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over enable, so a cleared cycle never reports terminal count.
    assign tc_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_phase_ctrl.sv
// Game-phase sequencer: phase FSM, lives, level and ball/barrier/bonus tick schedule.
// Optional bonus-ball scheduler is built when BONUS_BALL_EN is defined.
module game_phase_ctrl
    import game_pkg::*;
#(
    parameter int unsigned BALL_DIV     = 3,
    parameter int unsigned BONUS_PERIOD = 50,
    parameter int unsigned RESPAWN_HOLD = 10
) (
    input  logic       buttonclk,
    input  logic       reset,
    input  logic       start,
    input  logic       throw,
    input  logic       restart,
    input  logic       show_two_row,
    input  logic       ball_lost,
    input  logic       bricks_zero,
    input  logic       bonus_done,
    output logic [2:0] phase,
    output logic       hands_on,
    output logic       load_bricks,
    output logic       two_row,
    output logic       serve_init,
    output logic       ball_step,
    output logic       barrier_shift,
    output logic       bonus_fire,
    output logic       bonus_active,
    output logic [2:0] life,
    output logic [3:0] level,
    output logic       game_over
);

    logic [2:0] phase_q, phase_d;
    logic [2:0] life_q, life_d;
    logic [3:0] level_q, level_d;
    logic       two_row_q, two_row_d;
    logic       load_bricks_q, serve_init_q, step_q, hands_on_q, game_over_q;

    logic play_run, play_stay, play_lost, play_clear;
    logic serve_throw, hold_en, hold_tc, ball_tc;
    logic entering, enter_load, miss_to_serve, over_restart;

    // start=0 freezes every non-IDLE phase, so all advance conditions include it.
    assign play_run    = (phase_q == PH_PLAY) && start;
    assign play_clear  = play_run && bricks_zero;
    assign play_lost   = play_run && !bricks_zero && ball_lost;
    assign play_stay   = play_run && !bricks_zero && !ball_lost;
    assign serve_throw = (phase_q == PH_SERVE) && start && throw;
    assign hold_en     = (phase_q == PH_MISS) && start;

    tick_div #(.N(BALL_DIV)) u_ball_div (
        .buttonclk (buttonclk),
        .reset     (reset),
        .en_i      (play_stay),
        .clr_i     (serve_throw),
        .tc_o      (ball_tc)
    );

    tick_div #(.N(RESPAWN_HOLD)) u_hold_div (
        .buttonclk (buttonclk),
        .reset     (reset),
        .en_i      (hold_en),
        .clr_i     (play_lost),
        .tc_o      (hold_tc)
    );

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE:  if (start) phase_d = PH_LOAD;
            PH_LOAD:  if (start) phase_d = PH_SERVE;
            PH_SERVE: if (serve_throw) phase_d = PH_PLAY;
            PH_PLAY: begin
                if (play_clear) begin
                    phase_d = PH_CLEAR;
                end else if (play_lost) begin
                    phase_d = (life_q == LIFE_LAST) ? PH_OVER : PH_MISS;
                end
            end
            PH_MISS:  if (hold_tc) phase_d = PH_SERVE;
            PH_CLEAR: if (start) phase_d = PH_LOAD;
            PH_OVER:  if (start && restart) phase_d = PH_LOAD;
            default:  phase_d = PH_IDLE;
        endcase
    end

    assign entering      = (phase_d != phase_q);
    assign enter_load    = entering && (phase_d == PH_LOAD);
    assign miss_to_serve = (phase_q == PH_MISS) && (phase_d == PH_SERVE);
    assign over_restart  = (phase_q == PH_OVER) && enter_load;

    always_comb begin
        life_d    = life_q;
        level_d   = level_q;
        two_row_d = two_row_q;
        if (play_lost) begin
            life_d = {life_q[1:0], 1'b0};
        end else if (over_restart) begin
            life_d  = LIFE_FULL;
            level_d = '0;
        end
        if (entering && (phase_d == PH_CLEAR)) begin
            level_d = level_inc(level_q);
        end
        if ((phase_q == PH_LOAD) && start) begin
            two_row_d = show_two_row;
        end
    end

    // Pulses are registered on the transition edge so they coincide with the new phase.
    always_ff @(posedge buttonclk) begin
        if (reset) begin
            phase_q       <= PH_IDLE;
            life_q        <= LIFE_FULL;
            level_q       <= '0;
            two_row_q     <= 1'b0;
            load_bricks_q <= 1'b0;
            serve_init_q  <= 1'b0;
            step_q        <= 1'b0;
            hands_on_q    <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            life_q        <= life_d;
            level_q       <= level_d;
            two_row_q     <= two_row_d;
            load_bricks_q <= enter_load;
            serve_init_q  <= enter_load || miss_to_serve;
            step_q        <= ball_tc;
            hands_on_q    <= (phase_d == PH_SERVE);
            game_over_q   <= (phase_d == PH_OVER);
        end
    end

    assign phase         = phase_q;
    assign life          = life_q;
    assign level         = level_q;
    assign two_row       = two_row_q;
    assign load_bricks   = load_bricks_q;
    assign serve_init    = serve_init_q;
    assign ball_step     = step_q;
    assign barrier_shift = step_q;
    assign hands_on      = hands_on_q;
    assign game_over     = game_over_q;

`ifdef BONUS_BALL_EN
    logic bonus_clr, bonus_en, bonus_tc;
    logic bonus_fire_q, bonus_active_q;

    // Leaving PLAY (to MISS, CLEAR or OVER) drops any bonus ball and restarts the period.
    assign bonus_clr = entering && ((phase_d == PH_MISS) || (phase_d == PH_CLEAR) ||
                                    (phase_d == PH_OVER));
    assign bonus_en  = play_stay && !bonus_active_q;

    tick_div #(.N(BONUS_PERIOD)) u_bonus_div (
        .buttonclk (buttonclk),
        .reset     (reset),
        .en_i      (bonus_en),
        .clr_i     (bonus_clr),
        .tc_o      (bonus_tc)
    );

    always_ff @(posedge buttonclk) begin
        if (reset) begin
            bonus_fire_q   <= 1'b0;
            bonus_active_q <= 1'b0;
        end else begin
            bonus_fire_q <= bonus_tc;
            if (bonus_clr) begin
                bonus_active_q <= 1'b0;
            end else if (bonus_tc) begin
                bonus_active_q <= 1'b1;
            end else if (start && bonus_done) begin
                bonus_active_q <= 1'b0;
            end
        end
    end

    assign bonus_fire   = bonus_fire_q;
    assign bonus_active = bonus_active_q;
`else
    logic unused_bonus_done;

    assign unused_bonus_done = bonus_done;
    assign bonus_fire        = 1'b0;
    assign bonus_active      = 1'b0;
`endif

endmodule
